// File: rtl/uart_rx_buffered.sv
// Buffered 8N1 UART receiver: 2-FF input synchronizer, oversampled 3-sample majority vote,
// first-word-fall-through receive FIFO with a valid/ready pop port, sticky framing/overrun flags.
module uart_rx_buffered #(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int BAUD_RATE    = 115200,
    parameter int OVERSAMPLE   = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            rxd_i,
    output logic                            rvalid_o,
    input  logic                            rready_i,
    output logic [7:0]                      rdata_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
    output logic                            frame_err_o,
    output logic                            overrun_o,
    input  logic                            clr_err_i
);

    localparam int DIV   = (CLK_FREQ_MHZ * 1000000) / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SC_W-1:0]  SC_V0    = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]  SC_V1    = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0]  SC_VOTE  = SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

    logic                r_rx_meta;
    logic                r_rxs;
    logic [DIV_W-1:0]    r_div_cnt;
    state_e              r_state;
    logic [SC_W-1:0]     r_sc;
    logic [2:0]          r_bit_idx;
    logic                r_s0;
    logic                r_s1;
    logic [7:0]          r_shift;
    logic                r_push_req;
    logic                r_frame_err;
    logic                r_overrun;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_tick;
    logic                w_vote;
    logic                w_pop;
    logic                w_push;

    // Line idles high, so the synchronizer resets to 1 to avoid a phantom start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rxd_i;
            r_rxs     <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_vote = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_sc        <= '0;
            r_bit_idx   <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_shift     <= '0;
            r_push_req  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // NOTE: a later non-blocking assignment to the same register in this block overrides
            // this default, which gives one-cycle pulses and set-over-clear priority for free.
            r_push_req <= 1'b0;
            if (clr_err_i) r_frame_err <= 1'b0;
            if (w_tick) begin
                if (r_state inside {S_START, S_DATA, S_STOP})
                    r_sc <= (r_sc == SC_LAST) ? '0 : r_sc + SC_W'(1);
                if (r_sc == SC_V0) r_s0 <= r_rxs;
                if (r_sc == SC_V1) r_s1 <= r_rxs;
                case (r_state)
                    S_IDLE: begin
                        if (!r_rxs) begin
                            r_sc    <= '0;
                            r_state <= S_START;
                        end
                    end
                    S_START: begin
                        if (r_sc == SC_VOTE && w_vote) begin
                            r_state <= S_IDLE;
                        end else if (r_sc == SC_LAST) begin
                            r_bit_idx <= '0;
                            r_state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (r_sc == SC_VOTE) r_shift <= {w_vote, r_shift[7:1]};
                        if (r_sc == SC_LAST) begin
                            if (r_bit_idx == 3'd7) r_state <= S_STOP;
                            else                   r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                    S_STOP: begin
                        // Leaving at mid-stop leaves half a bit of slack for the next start edge.
                        if (r_sc == SC_VOTE) begin
                            if (w_vote) begin
                                r_push_req <= 1'b1;
                                r_state    <= S_IDLE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= S_BREAK;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (r_rxs) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_pop  = rvalid_o && rready_i;
    assign w_push = r_push_req && ((r_count != CNT_FULL) || w_pop);

    // NOTE: the storage array has no reset; rdata_o is gated by rvalid_o so stale
    // contents are never visible, and leaving it out keeps the array as plain flops.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (clr_err_i)               r_overrun <= 1'b0;
            if (r_push_req && !w_push)   r_overrun <= 1'b1;
        end
    end

    assign rvalid_o    = (r_count != '0);
    assign rdata_o     = rvalid_o ? r_mem[r_rptr] : 8'h00;
    assign count_o     = r_count;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: table-driven frame/pop vectors plus hand-written
// corner sequences, with a byte scoreboard queue filled on send and drained on pop.
`timescale 1ns/1ps
module tb_uart_rx_buffered;

    // Scaled line rate keeps the run short: DIV = 1e6 / (20833*16) = 3 clocks per tick.
    localparam int      CLK_MHZ = 1;
    localparam int      BAUD    = 20833;
    localparam int      OS      = 16;
    localparam int      DEPTH   = 16;
    localparam int      DIV     = (CLK_MHZ * 1000000) / (BAUD * OS);
    localparam realtime CLK_NS  = 1000.0;
    localparam realtime BIT_NS  = DIV * OS * CLK_NS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       rready = 1'b0;
    logic       clr_err = 1'b0;
    logic       rvalid;
    logic [7:0] rdata;
    logic [4:0] count;
    logic       frame_err;
    logic       overrun;

    uart_rx_buffered #(
        .CLK_FREQ_MHZ(CLK_MHZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .rxd_i(rxd), .rvalid_o(rvalid), .rready_i(rready),
        .rdata_o(rdata), .count_o(count), .frame_err_o(frame_err), .overrun_o(overrun),
        .clr_err_i(clr_err)
    );

    always #(CLK_NS / 2) clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];

    typedef enum logic {OP_SEND, OP_POP} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] data;
        logic       exp_valid;
        logic [7:0] exp_head;
        logic [4:0] exp_count;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input realtime bit_ns);
        rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #(bit_ns);
        end
        rxd = 1'b1;
        #(bit_ns);
    endtask

    task automatic pop_one(input string name);
        int n = 0;
        @(negedge clk);
        while (!rvalid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            check({name, " rvalid timeout"}, rvalid, 1'b1);
        end else if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: got unexpected byte 0x%0h, want none", name, rdata);
        end else begin
            check(name, rdata, exp_q.pop_front());
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic clear_errors();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // Start frames on a fixed tick phase so two launches see identical receiver timing.
    task automatic align_tick();
        @(negedge clk);
        while (cyc % DIV != 0) @(negedge clk);
    endtask

    int unsigned launch_a;
    int unsigned launch_b;
    int unsigned push_at;

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{OP_SEND, 8'h55, 1'b1, 8'h55, 5'd1};
        vecs[1] = '{OP_SEND, 8'hA3, 1'b1, 8'h55, 5'd2};
        vecs[2] = '{OP_POP,  8'h00, 1'b1, 8'hA3, 5'd1};
        vecs[3] = '{OP_POP,  8'h00, 1'b0, 8'h00, 5'd0};

        wait_clks(3);
        check("reset rvalid", rvalid, 1'b0);
        check("reset count", count, 5'd0);
        check("reset rdata", rdata, 8'h00);
        check("reset frame_err", frame_err, 1'b0);
        check("reset overrun", overrun, 1'b0);
        rst_n = 1'b1;
        wait_clks(2 * DIV * OS);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].op == OP_SEND) begin
                exp_q.push_back(vecs[i].data);
                send_byte(vecs[i].data, BIT_NS);
                wait_clks(4);
            end else begin
                pop_one($sformatf("vec%0d popped byte", i));
            end
            @(negedge clk);
            check($sformatf("vec%0d rvalid", i), rvalid, vecs[i].exp_valid);
            check($sformatf("vec%0d head", i), rdata, vecs[i].exp_head);
            check($sformatf("vec%0d count", i), count, vecs[i].exp_count);
        end

        // Short low glitch on an idle line must be rejected by the start-bit vote.
        rxd = 1'b0;
        #(7 * CLK_NS);
        rxd = 1'b1;
        wait_clks(3 * DIV * OS);
        check("glitch count", count, 5'd0);
        check("glitch rvalid", rvalid, 1'b0);
        check("glitch frame_err", frame_err, 1'b0);
        check("glitch overrun", overrun, 1'b0);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, BIT_NS);
        pop_one("byte after glitch");

        // 0xA5 with the stop bit held low for three bit times.
        rxd = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxd = (8'hA5 >> i) & 8'h01;
            #(BIT_NS);
        end
        rxd = 1'b0;
        #(3 * BIT_NS);
        rxd = 1'b1;
        #(2 * BIT_NS);
        @(negedge clk);
        check("break frame_err", frame_err, 1'b1);
        check("break count", count, 5'd0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, BIT_NS);
        wait_clks(4);
        check("after break count", count, 5'd1);
        check("frame_err stays sticky", frame_err, 1'b1);
        pop_one("byte after break");
        clear_errors();
        check("frame_err cleared", frame_err, 1'b0);

        // Fill to full with no consumer, then one more byte overruns.
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), BIT_NS);
        end
        wait_clks(4);
        check("full count", count, 5'd16);
        check("full no overrun yet", overrun, 1'b0);
        check("full head", rdata, 8'h00);

        push_at = 0;
        align_tick();
        launch_a = cyc;
        fork
            send_byte(8'h10, BIT_NS);
            begin
                for (int k = 0; k < 1000; k++) begin
                    @(negedge clk);
                    if (overrun) begin
                        push_at = cyc;
                        break;
                    end
                end
            end
        join
        wait_clks(4);
        check("overrun set", overrun, 1'b1);
        check("overrun count", count, 5'd16);
        check("overrun head untouched", rdata, 8'h00);

        // Same timing again, with a pop on exactly the push edge: no overrun, count holds.
        clear_errors();
        check("overrun cleared", overrun, 1'b0);
        if (push_at != 0) begin
            align_tick();
            launch_b = cyc;
            fork
                send_byte(8'h11, BIT_NS);
                begin
                    while (cyc != launch_b + (push_at - launch_a) - 1) @(negedge clk);
                    check("head at simultaneous pop", rdata, exp_q.pop_front());
                    rready = 1'b1;
                    @(negedge clk);
                    rready = 1'b0;
                end
            join
            exp_q.push_back(8'h11);
            wait_clks(4);
            check("pop+push count", count, 5'd16);
            check("pop+push overrun", overrun, 1'b0);
        end
        for (int i = 0; i < 16; i++) pop_one($sformatf("drain %0d", i));
        @(negedge clk);
        check("drained rvalid", rvalid, 1'b0);
        check("drained count", count, 5'd0);

        // +/-3% sender skew on random bytes.
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_byte(b, (i % 2 == 1) ? BIT_NS * 1.03 : BIT_NS * 0.97);
            if (i % 8 == 7) begin
                for (int j = 0; j < 8; j++) pop_one($sformatf("skew byte %0d", i - 7 + j));
            end
        end
        @(negedge clk);
        check("skew frame_err", frame_err, 1'b0);
        check("skew overrun", overrun, 1'b0);
        check("skew count", count, 5'd0);

        // Reset in the middle of a frame with one byte queued.
        exp_q.push_back(8'hC7);
        send_byte(8'hC7, BIT_NS);
        wait_clks(4);
        check("pre-reset count", count, 5'd1);
        rxd = 1'b0;
        #(4.5 * BIT_NS);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid reset rvalid", rvalid, 1'b0);
        check("mid reset count", count, 5'd0);
        check("mid reset rdata", rdata, 8'h00);
        exp_q.delete();
        rxd = 1'b1;
        #(BIT_NS);
        @(negedge clk);
        rst_n = 1'b1;
        #(2 * BIT_NS);
        exp_q.push_back(8'h96);
        send_byte(8'h96, BIT_NS);
        wait_clks(4);
        check("post reset count", count, 5'd1);
        pop_one("post reset byte");
        check("post reset frame_err", frame_err, 1'b0);
        check("scoreboard empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
